// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART TX path: byte width, default line timing,
// FIFO default depth and the occupancy-update helper used by uart_tx_fifo.
// Optional build macro: UART_TX_FIFO_OVF_EN (see uart_tx_fifo.sv).
package uart_tx_fifo_pkg;

  // Transmitter byte width; the FIFO data width defaults to this.
  localparam int UART_DATA_WIDTH = 8;

  // Default line timing, shared by the transmitter, the receiver and the
  // site that instantiates this FIFO.
  localparam int CLOCK_FREQ = 125_000_000;
  localparam int BAUD_RATE  = 115_200;

  // Default number of buffered bytes (power of two, at least 2).
  localparam int FIFO_DEPTH = 8;

  // How the occupancy counter moves in a given cycle.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_op_e;

  // A push and a pop in the same cycle cancel out.
  function automatic occ_op_e occ_op(input logic enq_fire, input logic deq_fire);
    if (enq_fire && !deq_fire) return OCC_INC;
    if (deq_fire && !enq_fire) return OCC_DEC;
    return OCC_HOLD;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ptr.sv
// Wrapping read/write pointer for uart_tx_fifo. Counts modulo 2**PTR_WIDTH,
// so with a power-of-two depth the wrap falls out of the natural overflow.
// Priority: rst (active-low, synchronous) > clr > ce.
module uart_tx_fifo_ptr #(
  parameter int PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 ce,
  output logic [PTR_WIDTH-1:0] ptr
);

  // Pointer register: clear on reset or flush, advance by one when enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of process evaluation order.
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (ce) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO between the UART TX data register and
// the UART transmitter. enq_ready/deq_valid come only from the registered
// occupancy count, so neither side's handshake depends on the other's.
// Optional build macro: UART_TX_FIFO_OVF_EN adds a sticky overflow flag;
// without it the overflow port is tied low and no flag register exists.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int WIDTH     = UART_DATA_WIDTH,
  parameter  int DEPTH     = FIFO_DEPTH,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   enq_data,
  input  logic               enq_valid,
  output logic               enq_ready,
  output logic [WIDTH-1:0]   deq_data,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [PTR_WIDTH:0] count,
  output logic               overflow
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic [PTR_WIDTH:0]   count_nxt;
  logic                 full;
  logic                 empty;
  logic                 enq_fire;
  logic                 deq_fire;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign enq_ready = !full;
  assign deq_valid = !empty;

  // Flush discards any same-cycle handshake, so it gates both fire strobes.
  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  // Head entry is read combinationally; stale when the FIFO is empty.
  assign deq_data = mem[rptr];

  uart_tx_fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .ce  (enq_fire),
    .ptr (wptr)
  );

  uart_tx_fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .ce  (deq_fire),
    .ptr (rptr)
  );

  // Storage write on an accepted enqueue.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; count/pointers alone say which
    // entries are live, so clearing it would only cost reset fan-out.
    if (enq_fire && rst) begin
      mem[wptr] <= enq_data;
    end
  end

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_nxt unassigned
    // (which would infer a latch).
    count_nxt = count;
    unique case (occ_op(enq_fire, deq_fire))
      OCC_INC: count_nxt = count + 1'b1;
      OCC_DEC: count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Occupancy register: reset > flush > update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // Sticky overflow: any write offered while full; flush wins over a new event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
    end else if (enq_valid && !enq_ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed steps from the test plan
// followed by a randomized run, all compared against a queue-based model.
module tb_uart_tx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] enq_data;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] deq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [3:0]       count;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: queue contents plus the sticky overflow bit.
  logic [WIDTH-1:0] model_q[$];
  bit               model_ovf;

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_data  (enq_data),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .deq_data  (deq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model before
  // the edge, then advance the model by the rules for that edge.
  task automatic cycle(input string tag, input bit ev, input logic [WIDTH-1:0] d,
                       input bit dr, input bit fl, input bit rn);
    bit exp_ready;
    bit exp_valid;
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    flush     = fl;
    rst       = rn;
    exp_ready = (model_q.size() < DEPTH);
    exp_valid = (model_q.size() > 0);
    #1;
    check({tag, ".count"},     32'(count),     32'(model_q.size()));
    check({tag, ".enq_ready"}, 32'(enq_ready), 32'(exp_ready));
    check({tag, ".deq_valid"}, 32'(deq_valid), 32'(exp_valid));
    check({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
    if (exp_valid) check({tag, ".deq_data"}, 32'(deq_data), 32'(model_q[0]));
    @(posedge clk);
    if (!rn || fl) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (dr && exp_valid) void'(model_q.pop_front());
      if (ev && exp_ready) model_q.push_back(d);
      if (ev && !exp_ready && OVF_EN) model_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] b;

    // Bring the DUT out of an unknown state before any comparison.
    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_q.delete();
    model_ovf = 1'b0;

    // Reset then idle.
    cycle("idle", 0, 8'h00, 0, 0, 1);
    cycle("idle", 0, 8'h00, 1, 0, 1);

    // Three bytes in, held, then drained in order.
    cycle("enq3", 1, 8'h41, 0, 0, 1);
    cycle("enq3", 1, 8'h42, 0, 0, 1);
    cycle("enq3", 1, 8'h43, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle("drain3", 0, 8'h00, 1, 0, 1);
    cycle("drained", 0, 8'h00, 0, 0, 1);

    // Fill to full, then a write offered while a dequeue happens: dropped.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, WIDTH'(i), 0, 0, 1);
    cycle("full_wr", 1, 8'hFF, 1, 0, 1);
    cycle("after_full", 0, 8'h00, 0, 0, 1);
    cycle("after_full2", 0, 8'h00, 0, 0, 1);
    cycle("flush_full", 0, 8'h00, 0, 1, 1);

    // Streaming at occupancy 1 across two pointer wraps.
    cycle("stream", 1, 8'h80, 0, 0, 1);
    for (int i = 1; i < 20; i++) cycle("stream", 1, WIDTH'(8'h80 + i), 1, 0, 1);
    cycle("stream_end", 0, 8'h00, 1, 0, 1);
    cycle("stream_idle", 0, 8'h00, 0, 0, 1);

    // Flush at count 5 with a same-cycle enqueue; the byte must not appear.
    for (int i = 0; i < 5; i++) cycle("pre_flush", 1, WIDTH'(8'h10 + i), 0, 0, 1);
    cycle("flush_enq", 1, 8'hEE, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle("post_flush", 0, 8'h00, 1, 0, 1);

    // Reset while partially full.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1, WIDTH'(8'h20 + i), 0, 0, 1);
    cycle("mid_rst", 1, 8'h99, 1, 0, 0);
    cycle("post_rst", 0, 8'h00, 1, 0, 1);

    // Randomized traffic with rare flushes and resets.
    for (int i = 0; i < 600; i++) begin
      b = WIDTH'($urandom_range(0, 255));
      cycle("rand", ($urandom_range(0, 99) < 60), b, ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 127) != 0));
    end
    cycle("final", 0, 8'h00, 1, 1, 1);
    cycle("final", 0, 8'h00, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synchronous first-word-fall-through FIFO between the memory-mapped UART TX data register and the UART transmitter. The CPU side pushes bytes faster than the line can send them. The FIFO buffers them and presents them to the transmitter's data_in/data_in_valid/data_in_ready ready-valid port. It also reports occupancy so software can poll for space.

Parameters:
WIDTH, 8, data width in bits; matches the transmitter byte width.
DEPTH, 8, number of entries; must be a power of two and at least 2.
PTR_WIDTH, $clog2(DEPTH), read/write pointer width; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-low (0 = reset).
flush  input  1  synchronous clear of FIFO contents; active-high.
enq_data  input  WIDTH  byte to enqueue.
enq_valid  input  1  enqueue request.
enq_ready  output  1  FIFO can accept; equals !full.
deq_data  output  WIDTH  head entry; drives transmitter data_in.
deq_valid  output  1  FIFO non-empty; drives transmitter data_in_valid.
deq_ready  input  1  consumer accepts; driven from transmitter data_in_ready.
count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky overflow flag; see Optional Feature.

Behaviour:
- State: write pointer wptr, read pointer rptr (PTR_WIDTH each), occupancy count (PTR_WIDTH+1). Storage array of DEPTH x WIDTH, not reset.
- enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
- full = (count == DEPTH); empty = (count == 0).
- enq_ready = !full; deq_valid = !empty. Both are combinational from registered count only; neither depends on the other side's valid/ready.
- deq_data = mem[rptr], read combinationally (FWFT). deq_data is don't-care when deq_valid = 0.
- On enq_fire: mem[wptr] <= enq_data; wptr <= wptr + 1, wrapping modulo DEPTH.
- On deq_fire: rptr <= rptr + 1, wrapping modulo DEPTH.
- count update:
  - enq_fire only: +1.
  - deq_fire only: -1.
  - both or neither: unchanged.
- Latency: a byte enqueued at edge N is visible on deq_valid/deq_data after edge N. There is no same-cycle bypass when empty.
- Full boundary: enq_ready = 0, so a write offered while full is dropped even if deq_fire occurs in the same cycle. enq_ready returns to 1 the cycle after the dequeue.
- Empty boundary: deq_valid = 0, so deq_ready is ignored and rptr is unchanged.
- Simultaneous enq_fire and deq_fire at count = 1: new head is the enqueued byte; count stays 1.
- Priority order: reset > flush > enq/deq. Flush clears wptr, rptr and count to 0 at the next edge and discards same-cycle enq/deq. Storage contents are left stale.
- Reset values: wptr = 0, rptr = 0, count = 0, overflow = 0. Resulting outputs: enq_ready = 1, deq_valid = 0, count = 0.
- Reset asserted mid-operation (partially full FIFO, or transmitter mid-byte): FIFO empties at that edge. The transmitter is reset by the same rst and drops its in-flight byte; no partial handshake survives.
- The FIFO never drives deq_valid low while holding data; the transmitter may stall indefinitely.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- Defined: overflow sets at the edge after any cycle with enq_valid = 1 and enq_ready = 0. It stays set until reset or flush; flush clears it even if an overflow event occurs in the same cycle.
- Undefined: overflow tied to 0 and no flag register is instantiated. The port exists in both builds so the MMIO wrapper is unchanged.

Decomposition:
- Shared package/header uart_pkg:
  - UART_DATA_WIDTH = 8.
  - Default CLOCK_FREQ = 125_000_000 and BAUD_RATE = 115_200, shared by the transmitter, the receiver and this FIFO's instantiation site.
- Pointers and count use the existing REGISTER_R_CE primitives; storage is a plain reg array.
- One natural sub-module: fifo_ptr, a wrapping PTR_WIDTH counter with ce and synchronous clear, instantiated twice (wptr, rptr).

Test Plan:
- Reset then idle -> enq_ready = 1, deq_valid = 0, count = 0, overflow = 0.
- Enqueue 0x41, 0x42, 0x43 on consecutive cycles with deq_ready = 0 -> count = 3, deq_data = 0x41. Then deq_ready = 1 for 3 cycles -> 0x41, 0x42, 0x43 in order, count = 0, deq_valid = 0.
- Fill 8 entries (0x00..0x07), then offer 0xFF with deq_ready = 1 in the same cycle -> 0xFF dropped, count = 7, head = 0x01. With OVF_EN, overflow = 1.
- Continuous enqueue/dequeue for 20 bytes with count held at 1 -> pointers wrap twice, output sequence equals input sequence, count stays 1.
- Count = 5, assert flush together with enq_valid = 1 -> next cycle count = 0, deq_valid = 0, overflow = 0; the enqueued byte does not appear later.
- Connected to the transmitter at CLOCK_FREQ/BAUD_RATE = 4, enqueue 0x55, 0xA3 back-to-back -> serial_out carries two 10-bit frames in order, and the FIFO empties after the second data_in_ready handshake.
